// File: rtl/alu_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter_if
// Description : Request, ALU and response signals shared by alu_arbiter and
//               the logic around it.
// Revision    : 1.0
// ============================================================================
interface alu_arbiter_if #(
  parameter int WIDTH = 32
);
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [1:0]       req0_op;
  logic [1:0]       req1_op;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [1:0]       alu_ctrl;
  logic [WIDTH-1:0] alu_out;
  logic             alu_zero;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_out;
  logic             rsp_zero;
  logic             rsp_err;

  // Requesters, response sink and the ALU itself
  modport master (
    output req_valid, req0_a, req0_b, req1_a, req1_b, req0_op, req1_op,
    output alu_out, alu_zero, rsp_ready,
    input  req_ready, alu_a, alu_b, alu_ctrl,
    input  rsp_valid, rsp_id, rsp_out, rsp_zero, rsp_err
  );

  modport slave (
    input  req_valid, req0_a, req0_b, req1_a, req1_b, req0_op, req1_op,
    input  alu_out, alu_zero, rsp_ready,
    output req_ready, alu_a, alu_b, alu_ctrl,
    output rsp_valid, rsp_id, rsp_out, rsp_zero, rsp_err
  );
endinterface
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter
// Description : Two-requester round-robin front end for a shared ALU with a
//               tagged valid/ready response channel. Optional reserved-op
//               check enabled by defining ALU_ARB_OPCHK_EN.
// Revision    : 1.0
// ============================================================================
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  wire logic     clk,
  input  wire logic     reset_n,
  alu_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [1:0] c_op_rsvd = 2'd3;

  state_t           r_state;
  logic             r_last_grant;
  logic             r_id;
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic [1:0]       r_alu_ctrl;
  logic             r_rsp_valid;
  logic             r_rsp_id;
  logic [WIDTH-1:0] r_rsp_out;
  logic             r_rsp_zero;

  logic             w_grant_id;
  logic             w_take;
  logic [WIDTH-1:0] w_sel_a;
  logic [WIDTH-1:0] w_sel_b;
  logic [1:0]       w_sel_op;

  // On a tie the requester that did not win last time is served
  always_comb begin
    w_grant_id = 1'b0;
    if (bus.req_valid == 2'b11) begin
      w_grant_id = ~r_last_grant;
    end else if (bus.req_valid[1]) begin
      w_grant_id = 1'b1;
    end
  end

  assign w_take   = (r_state == S_IDLE) && (|bus.req_valid);
  assign w_sel_a  = w_grant_id ? bus.req1_a  : bus.req0_a;
  assign w_sel_b  = w_grant_id ? bus.req1_b  : bus.req0_b;
  assign w_sel_op = w_grant_id ? bus.req1_op : bus.req0_op;

  assign bus.req_ready = w_take ? (w_grant_id ? 2'b10 : 2'b01) : 2'b00;

`ifdef ALU_ARB_OPCHK_EN
  logic r_err_pend;
  logic r_rsp_err;
  logic w_sel_rsvd;

  assign w_sel_rsvd  = (w_sel_op == c_op_rsvd);
  assign bus.rsp_err = r_rsp_err;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_err_pend <= 1'b0;
      r_rsp_err  <= 1'b0;
    end else if (w_take) begin
      r_err_pend <= w_sel_rsvd;
    end else if (r_state == S_EXEC) begin
      r_rsp_err  <= r_err_pend;
    end
  end
`else
  assign bus.rsp_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_id         <= 1'b0;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_ctrl   <= 2'd0;
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= 1'b0;
      r_rsp_out    <= '0;
      r_rsp_zero   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_take) begin
            r_alu_a      <= w_sel_a;
            r_alu_b      <= w_sel_b;
`ifdef ALU_ARB_OPCHK_EN
            // Reserved op never reaches the ALU
            r_alu_ctrl   <= w_sel_rsvd ? 2'd0 : w_sel_op;
`else
            r_alu_ctrl   <= w_sel_op;
`endif
            r_id         <= w_grant_id;
            r_last_grant <= w_grant_id;
            r_state      <= S_EXEC;
          end
        end
        S_EXEC: begin
`ifdef ALU_ARB_OPCHK_EN
          r_rsp_out    <= r_err_pend ? '0   : bus.alu_out;
          r_rsp_zero   <= r_err_pend ? 1'b0 : bus.alu_zero;
`else
          r_rsp_out    <= bus.alu_out;
          r_rsp_zero   <= bus.alu_zero;
`endif
          r_rsp_id     <= r_id;
          r_rsp_valid  <= 1'b1;
          r_state      <= S_RESP;
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.alu_a     = r_alu_a;
  assign bus.alu_b     = r_alu_b;
  assign bus.alu_ctrl  = r_alu_ctrl;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_id    = r_rsp_id;
  assign bus.rsp_out   = r_rsp_out;
  assign bus.rsp_zero  = r_rsp_zero;

endmodule
`default_nettype wire

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester round-robin arbiter that shares the single 32-bit ALU between requesters. It sits in front of the ALU and drives its operand and control inputs from registers. It captures the ALU result and zero flag, then returns them through a valid/ready response channel tagged with the requester ID. One operation is in flight at a time.

## Interface
- WIDTH, 32, operand/result width; must match ALU width
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  2  per-requester request valid (bit i = requester i)
- req_ready  out  2  per-requester accept; at most one bit high
- req0_a, req0_b  in  WIDTH  requester 0 operands
- req1_a, req1_b  in  WIDTH  requester 1 operands
- req0_op, req1_op  in  2  ALU op: 0 add, 1 sub, 2 or, 3 reserved
- alu_a, alu_b  out  WIDTH  registered operands to ALU
- alu_ctrl  out  2  registered op to ALU
- alu_out  in  WIDTH  ALU result (combinational from alu_a/alu_b/alu_ctrl)
- alu_zero  in  1  ALU equality flag (a==b)
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accept
- rsp_id  out  1  requester the response belongs to
- rsp_out  out  WIDTH  captured result
- rsp_zero  out  1  captured zero flag
- rsp_err  out  1  reserved-op flag (see Configuration)

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Arbitrate among req_valid bits. If exactly one is valid, grant it.
  - If both are valid, grant the requester that is not last_grant.
  - req_ready is combinational and asserted only for the granted bit, only in IDLE.
  - On handshake (req_valid[i] & req_ready[i]): latch operands/op into alu_a/alu_b/alu_ctrl, set id_q=i and last_grant=i, go to EXEC.
- EXEC (exactly 1 cycle): capture alu_out→rsp_out, alu_zero→rsp_zero, id_q→rsp_id; set rsp_valid=1; go to RESP.
- RESP:
  - Hold all rsp_* stable while rsp_valid & !rsp_ready.
  - On rsp_valid & rsp_ready: clear rsp_valid and go to IDLE. New requests are not accepted in that same cycle.
- alu_a/alu_b/alu_ctrl hold their last values outside EXEC (no toggling).
- Arithmetic is entirely the ALU's: wrap-around modulo 2^WIDTH, no carry/overflow output.
- Requests are never dropped: a non-granted requester keeps req_valid and is served next. Round robin guarantees it waits at most one operation.
- A requester may deassert req_valid before being granted; no state changes.

## Timing
- Reset values: state=IDLE, last_grant=1 (requester 0 wins first tie), req_ready=0 unless a valid request is present in IDLE, alu_a=alu_b=0, alu_ctrl=0, rsp_valid=0, rsp_id=0, rsp_out=0, rsp_zero=0, rsp_err=0.
- Latency:
  - Handshake at edge T → alu_* updated after T.
  - rsp_valid high after edge T+1.
  - With rsp_ready held high, the response is consumed at edge T+2 and IDLE is re-entered after T+2.
  - Maximum throughput is 1 op / 3 cycles.
- Simultaneous req_valid with rsp_valid in RESP: the request waits; no req_ready until IDLE.
- Reset asserted in any state: immediate return to reset values. An in-flight op is abandoned with no response.
- Reset deassertion is synchronised externally; the first accept may occur on the first edge after release.

## Configuration
- ALU_ARB_OPCHK_EN defined:
  - A request with op==3 is still accepted and sequenced normally.
  - In EXEC it captures rsp_out=0, rsp_zero=0, rsp_err=1. alu_ctrl is driven 0 for that op, so the undefined ALU output is never sampled.
  - rsp_err=0 for ops 0–2.
- ALU_ARB_OPCHK_EN undefined: op passes to alu_ctrl unchanged, rsp_out/rsp_zero are captured as-is, and rsp_err is tied 0.

## Test plan
- Single op: req0 a=5, b=3, op=0, rsp_ready=1 → req_ready=2'b01 in cycle 0; rsp_valid in cycle 2 with rsp_out=8, rsp_zero=0, rsp_id=0.
- Tie and round robin: req0 and req1 valid continuously from reset, both with a=9, b=9, op=1 → grants alternate 0,1,0,1; each response has rsp_out=0, rsp_zero=1, rsp_id matching the grant order.
- Backpressure: req1 a=0xF0, b=0x0F, op=2, rsp_ready=0 for 4 cycles → rsp_valid, rsp_out=0xFF, rsp_id=1 stable for all 4 cycles; req_ready stays 0 until a cycle after rsp_ready=1.
- Wrap-around: req0 a=0xFFFFFFFF, b=1, op=0 → rsp_out=0, rsp_zero=0; then a=0, b=1, op=1 → rsp_out=0xFFFFFFFF.
- Reserved op with ALU_ARB_OPCHK_EN: req0 op=3, a=7, b=7 → rsp_out=0, rsp_zero=0, rsp_err=1. Without the macro, rsp_err=0.
- Reset mid-op: reset_n low during EXEC, then high → no rsp_valid and all outputs at reset values. Next request from req0 is granted first.
